// File: rtl/ei_axi4_slave_pkg.sv
// Shared types and constants for the AXI4 slave memory model.
package ei_axi4_slave_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_e;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        SLVERR = 2'd2
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_e;

    localparam int unsigned BOUNDARY_4K = 4096;
    localparam int unsigned B4K_SHIFT   = $clog2(BOUNDARY_4K);

endpackage

// File: rtl/ei_axi4_addr_gen.sv
// Next beat address for FIXED, INCR and WRAP bursts (combinational).
module ei_axi4_addr_gen
    import ei_axi4_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr_c
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] mask;

    always_comb begin
        step        = ADDR_WIDTH'(1) << size;
        incr        = addr + step;
        // wrap boundary is (len+1)*step; mask keeps the offset within it
        mask        = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        next_addr_c = addr;
        case (burst_e'(burst))
            INCR:    next_addr_c = incr;
            WRAP:    next_addr_c = (addr & ~mask) | (incr & mask);
            default: next_addr_c = addr;
        endcase
    end

endmodule

// File: rtl/ei_axi4_slave_mem.sv
// AXI4 slave memory: one outstanding write and one outstanding read, running independently.
module ei_axi4_slave_mem
    import ei_axi4_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int unsigned STRB   = DATA_WIDTH / 8;
    localparam int unsigned BSHIFT = $clog2(STRB);
    localparam int unsigned IW     = $clog2(MEM_DEPTH);
    localparam int unsigned XW     = ADDR_WIDTH + 16;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    wstate_e               wstate;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr, w_addr_nxt;
    logic [7:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic                  w_err, w_lerr;

    rstate_e               rstate;
    logic [ADDR_WIDTH-1:0] r_addr, r_addr_nxt;
    logic [7:0]            r_len, r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;

    // Whole-burst legality, judged once from the command
    function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic [XW-1:0] a, span, hi;
        logic          err;
        a    = XW'(addr);
        span = XW'(len) << size;
        hi   = a;
        err  = 1'b0;
        case (burst_e'(burst))
            INCR: begin
                hi  = a + span;
                err = (a >> B4K_SHIFT) != (hi >> B4K_SHIFT);
            end
            WRAP: begin
                hi  = (a & ~(span + (XW'(1) << size) - XW'(1))) + span;
                err = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
            end
            default: hi = a;
        endcase
        if (32'(size) > BSHIFT) err = 1'b1;
        if ((hi >> BSHIFT) >= XW'(MEM_DEPTH)) err = 1'b1;
        return err;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rd_word(input logic [ADDR_WIDTH-1:0] a);
        if ((XW'(a) >> BSHIFT) < XW'(MEM_DEPTH)) return mem[a[BSHIFT +: IW]];
        return '0;
    endfunction

    ei_axi4_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_wgen (
        .addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst), .next_addr_c(w_addr_nxt)
    );

    ei_axi4_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_rgen (
        .addr(r_addr), .size(r_size), .len(r_len), .burst(r_burst), .next_addr_c(r_addr_nxt)
    );

    // Write channel FSM
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate  <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
            bid     <= '0;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            w_lerr  <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        w_id    <= awid;
                        w_addr  <= awaddr;
                        w_len   <= awlen;
                        w_size  <= awsize;
                        w_burst <= awburst;
                        w_cnt   <= '0;
                        w_err   <= burst_err(awaddr, awlen, awsize, awburst);
                        w_lerr  <= 1'b0;
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid && wready) begin
                        w_addr <= w_addr_nxt;
                        w_cnt  <= w_cnt + 8'd1;
                        // beat count ends the burst; a misplaced wlast only taints bresp
                        if (w_cnt == w_len) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bid    <= w_id;
                            bresp  <= (w_err || w_lerr || !wlast) ? SLVERR : OKAY;
                            wstate <= W_RESP;
                        end else if (wlast) begin
                            w_lerr <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wstate  <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Memory array is never reset; erroneous bursts never reach it
    always_ff @(posedge aclk) begin
        if (wstate == W_DATA && wvalid && wready && !w_err) begin
            for (int unsigned b = 0; b < STRB; b++) begin
                if (wstrb[b]) mem[w_addr[BSHIFT +: IW]][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Read channel FSM; rdata is prefetched on each handshake
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rstate  <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rresp   <= OKAY;
            rid     <= '0;
            rdata   <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (arvalid && arready) begin
                        r_addr  <= araddr;
                        r_len   <= arlen;
                        r_size  <= arsize;
                        r_burst <= arburst;
                        r_cnt   <= '0;
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        rid     <= arid;
                        rresp   <= burst_err(araddr, arlen, arsize, arburst) ? SLVERR : OKAY;
                        rlast   <= (arlen == 8'd0);
                        rdata   <= rd_word(araddr);
                        rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            rstate  <= R_IDLE;
                        end else begin
                            r_addr <= r_addr_nxt;
                            r_cnt  <= r_cnt + 8'd1;
                            rlast  <= (r_cnt + 8'd1 == r_len);
                            rdata  <= rd_word(r_addr_nxt);
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
// Randomized bench for ei_axi4_slave_mem against a byte-level memory model.
module tb_ei_axi4_slave_mem;

    localparam int DEPTH = 1024;
    localparam int BF = 0, BI = 1, BW = 2;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  awid = '0, arid = '0, bid, rid;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [2:0]  awsize = '0, arsize = '0;
    logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
    logic        arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid, rlast;

    int checks = 0;
    int errors = 0;

    bit   [31:0] mdl   [DEPTH];
    bit   [3:0]  known [DEPTH];
    logic [31:0] wd     [16];
    logic [3:0]  ws     [16];
    logic [31:0] rbeats [16];
    logic [1:0]  rresps [16];

    always #5 aclk = ~aclk;

    ei_axi4_slave_mem dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint beat_addr(longint addr, int len, int size, int burst, int i);
        longint step = longint'(1) << size;
        longint bound, base;
        if (burst == BI) return addr + i * step;
        if (burst == BW) begin
            bound = (len + 1) * step;
            base  = (addr / bound) * bound;
            return base + ((addr - base + i * step) % bound);
        end
        return addr;
    endfunction

    function automatic bit calc_err(longint addr, int len, int size, int burst);
        longint step = longint'(1) << size;
        if (size > 2) return 1'b1;
        if (burst == BW && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
        if (burst == BI && (addr / 4096) != ((addr + len * step) / 4096)) return 1'b1;
        for (int i = 0; i <= len; i++)
            if (beat_addr(addr, len, size, burst, i) / 4 >= DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Uses wd/ws; bad_last >= 0 puts the only wlast on that beat index
    task automatic do_write(input longint addr, input int len, input int size, input int burst,
                            input int id, input int bad_last);
        bit err;
        int n;
        int w;
        longint a;
        err = calc_err(addr, len, size, burst);
        awid = 4'(id); awaddr = 32'(addr); awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
        awvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < 20) begin tick(); n++; end
        if (n == 20) begin check("aw_timeout", 0, 1); awvalid = 1'b0; return; end
        tick();
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i];
            wlast = (bad_last >= 0) ? (i == bad_last) : (i == len);
            if (i == 0) check("wready_after_aw", wready, 1);
            n = 0;
            while (wready !== 1'b1 && n < 20) begin tick(); n++; end
            if (n == 20) begin check("w_timeout", 0, 1); wvalid = 1'b0; return; end
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("bvalid_lat", bvalid, 1);
        repeat ($urandom_range(0, 2)) begin tick(); check("bvalid_hold", bvalid, 1); end
        check("bresp", bresp, (err || bad_last >= 0) ? 2 : 0);
        check("bid", bid, id);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("bvalid_clr", bvalid, 0);
        if (!err) begin
            for (int i = 0; i <= len; i++) begin
                a = beat_addr(addr, len, size, burst, i);
                w = int'(a / 4);
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) begin
                        mdl[w][8*b +: 8] = wd[i][8*b +: 8];
                        known[w][b] = 1'b1;
                    end
            end
        end
    endtask

    task automatic do_read(input longint addr, input int len, input int size, input int burst,
                           input int id, input int stall_beat, input int stall_cyc);
        bit err;
        int n;
        int w;
        logic [31:0] mask, hold_d;
        logic hold_l;
        err = calc_err(addr, len, size, burst);
        arid = 4'(id); araddr = 32'(addr); arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
        arvalid = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < 20) begin tick(); n++; end
        if (n == 20) begin check("ar_timeout", 0, 1); arvalid = 1'b0; return; end
        tick();
        arvalid = 1'b0;
        check("rvalid_lat", rvalid, 1);
        for (int i = 0; i <= len; i++) begin
            if (rvalid !== 1'b1) begin check("rvalid_drop", rvalid, 1); rready = 1'b0; return; end
            if (i == stall_beat && stall_cyc > 0) begin
                hold_d = rdata; hold_l = rlast;
                rready = 1'b0;
                repeat (stall_cyc) tick();
                check("stall_valid", rvalid, 1);
                check("stall_data", rdata, hold_d);
                check("stall_last", rlast, hold_l);
            end
            rready = 1'b1;
            w = int'(beat_addr(addr, len, size, burst, i) / 4);
            if (!err) begin
                mask = '0;
                for (int b = 0; b < 4; b++) if (known[w][b]) mask[8*b +: 8] = 8'hFF;
                check("rdata", rdata & mask, mdl[w] & mask);
            end
            check("rresp", rresp, err ? 2 : 0);
            check("rid", rid, id);
            check("rlast", rlast, i == len);
            rbeats[i] = rdata;
            rresps[i] = rresp;
            tick();
        end
        rready = 1'b0;
        check("rvalid_end", rvalid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int burst, size, len, bad;
        longint addr;

        // reset values
        #12;
        check("rst_awready", awready, 0);
        check("rst_arready", arready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_bresp", bresp, 0);
        check("rst_rdata", rdata, 0);
        tick();
        aresetn = 1'b1;
        check("pre_edge_awready", awready, 0);
        tick();
        check("idle_awready", awready, 1);
        check("idle_arready", arready, 1);

        // INCR write then read back
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
        do_write(32'h10, 3, 2, BI, 3, -1);
        do_read(32'h10, 3, 2, BI, 5, -1, 0);
        for (int i = 0; i < 4; i++) check("incr_const", rbeats[i], 32'hA0 + 32'(i));

        // WRAP read order 0x38, 0x3C, 0x30, 0x34
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h3000 + 32'(4 * i); ws[i] = 4'hF; end
        do_write(32'h30, 3, 2, BI, 1, -1);
        do_read(32'h38, 3, 2, BW, 2, -1, 0);
        check("wrap_b0", rbeats[0], 32'h3008);
        check("wrap_b1", rbeats[1], 32'h300C);
        check("wrap_b2", rbeats[2], 32'h3000);
        check("wrap_b3", rbeats[3], 32'h3004);

        // byte strobes
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(32'h0, 0, 2, BI, 4, -1);
        wd[0] = 32'h11223344; ws[0] = 4'h3;
        do_write(32'h0, 0, 2, BI, 4, -1);
        do_read(32'h0, 0, 2, BI, 4, -1, 0);
        check("strb_merge", rbeats[0], 32'hDEAD3344);

        // out-of-range write must not alias onto word 0
        wd[0] = 32'h55555555; ws[0] = 4'hF;
        do_write(32'h1000, 0, 2, BI, 6, -1);
        do_read(32'h0, 0, 2, BI, 6, -1, 0);
        check("oor_unchanged", rbeats[0], 32'hDEAD3344);
        do_read(32'hFFC, 1, 2, BI, 7, -1, 0);
        check("slverr_b0", rresps[0], 2);
        check("slverr_b1", rresps[1], 2);

        // backpressure mid-burst, then misplaced wlast
        do_read(32'h10, 3, 2, BI, 8, 2, 3);
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h200 + 32'(i); ws[i] = 4'hF; end
        do_write(32'h200, 3, 2, BI, 9, 1);
        do_read(32'h200, 3, 2, BI, 9, -1, 0);
        check("wlast_err_data", rbeats[3], 32'h203);

        // reset during the second read beat
        arid = 4'd2; araddr = 32'h10; arlen = 8'd3; arsize = 3'd2; arburst = 2'(BI);
        arvalid = 1'b1;
        tick();
        tick();
        arvalid = 1'b0;
        rready = 1'b1;
        tick();
        check("rst_mid_beat2", rdata, 32'hA1);
        aresetn = 1'b0;
        #1;
        check("rst_mid_rvalid", rvalid, 0);
        rready = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        check("rst_mid_arready", arready, 1);
        do_read(32'h10, 3, 2, BI, 3, -1, 0);

        // randomized mix
        for (int t = 0; t < 60; t++) begin
            burst = $urandom_range(0, 2);
            size  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            if (burst == BW) begin
                case ($urandom_range(0, 4))
                    0: len = 1;
                    1: len = 3;
                    2: len = 7;
                    3: len = 15;
                    default: len = 2;
                endcase
            end else begin
                len = $urandom_range(0, 7);
            end
            addr = ($urandom_range(0, 6) == 0) ? longint'(32'hFC0 + $urandom_range(0, 127))
                                               : longint'($urandom_range(0, 511));
            addr = addr & ~((longint'(1) << size) - 1);
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
                bad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
                if (bad == len) bad = -1;
                do_write(addr, len, size, burst, $urandom_range(0, 15), bad);
            end else begin
                do_read(addr, len, size, burst, $urandom_range(0, 15),
                        $urandom_range(0, len), $urandom_range(0, 3));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
